// File: rtl/exc_arbiter_if.sv
// rtl/exc_arbiter_if.sv - request/response bundle between decode stage, exception arbiter and CP0
interface exc_arbiter_if;
   logic        syscall_req;
   logic        break_req;
   logic        teq_req;
   logic        eret_req;
   logic        int_req;
   logic [31:0] pc_in;
   logic [31:0] status;
   logic        exception;
   logic        eret;
   logic [4:0]  cause;
   logic [31:0] exc_pc;
   logic        pc_redirect;
   logic        pipe_stall;
   logic        int_pending;

   modport master (
      output syscall_req, break_req, teq_req, eret_req, int_req, pc_in, status,
      input  exception, eret, cause, exc_pc, pc_redirect, pipe_stall, int_pending
   );

   modport slave (
      input  syscall_req, break_req, teq_req, eret_req, int_req, pc_in, status,
      output exception, eret, cause, exc_pc, pc_redirect, pipe_stall, int_pending
   );
endinterface

// File: rtl/exc_arbiter.sv
// rtl/exc_arbiter.sv - prioritises exceptions/eret/interrupts and sequences CP0 pulses and pipeline stalls
module exc_arbiter #(
   parameter int HOLD_CYCLES = 2
) (
   input logic          clk,
   input logic          rst_n,
   exc_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      TAKE = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam logic [3:0] HOLD_LOAD = (HOLD_CYCLES > 0) ? 4'(HOLD_CYCLES - 1) : 4'd0;

   localparam logic [4:0] CAUSE_INT     = 5'd0;
   localparam logic [4:0] CAUSE_SYSCALL = 5'd8;
   localparam logic [4:0] CAUSE_BREAK   = 5'd9;
   localparam logic [4:0] CAUSE_TEQ     = 5'd13;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        sync1_q, sync1_d;
   logic        sync2_q, sync2_d;
   logic        sync3_q, sync3_d;
   logic        int_pending_q, int_pending_d;
   logic [4:0]  cause_q, cause_d;
   logic [31:0] exc_pc_q, exc_pc_d;
   logic        exception_q, exception_d;
   logic        eret_q, eret_d;
   logic        redirect_q, redirect_d;
   logic        stall_q, stall_d;

   logic        accept;
   logic        acc_eret;
   logic        take_int;
   logic [4:0]  acc_cause;

   // Only IE is consumed from Status; the rest of the word is ignored.
   logic unused_status;
   assign unused_status = ^bus.status[31:1];

   // Priority pick in IDLE plus next-state / registered-output computation.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cause_d     = cause_q;
      exc_pc_d    = exc_pc_q;
      exception_d = 1'b0;
      eret_d      = 1'b0;
      redirect_d  = 1'b0;
      stall_d     = 1'b0;
      sync1_d     = bus.int_req;
      sync2_d     = sync1_q;
      sync3_d     = sync2_q;
      accept      = 1'b0;
      acc_eret    = 1'b0;
      take_int    = 1'b0;
      acc_cause   = CAUSE_INT;

      // rst_n gating keeps the combinational stall low while reset is held.
      if (state_q == IDLE && rst_n) begin
         if (bus.syscall_req) begin
            accept    = 1'b1;
            acc_cause = CAUSE_SYSCALL;
         end else if (bus.break_req) begin
            accept    = 1'b1;
            acc_cause = CAUSE_BREAK;
         end else if (bus.teq_req) begin
            accept    = 1'b1;
            acc_cause = CAUSE_TEQ;
         end else if (bus.eret_req) begin
            accept    = 1'b1;
            acc_eret  = 1'b1;
         end else if (int_pending_q && bus.status[0]) begin
            accept    = 1'b1;
            take_int  = 1'b1;
            acc_cause = CAUSE_INT;
         end
      end

      // A fresh synchronized edge wins over the clear of an accepted interrupt.
      int_pending_d = (sync2_q & ~sync3_q) | (int_pending_q & ~take_int);

      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d     = TAKE;
               stall_d     = 1'b1;
               redirect_d  = 1'b1;
               exception_d = ~acc_eret;
               eret_d      = acc_eret;
               if (!acc_eret) begin
                  cause_d  = acc_cause;
                  exc_pc_d = bus.pc_in;
               end
            end
         end
         TAKE: begin
            if (HOLD_CYCLES == 0) begin
               state_d = IDLE;
            end else begin
               state_d = HOLD;
               cnt_d   = HOLD_LOAD;
               stall_d = 1'b1;
            end
         end
         HOLD: begin
            if (cnt_q == 4'd0) begin
               state_d = IDLE;
            end else begin
               cnt_d   = cnt_q - 4'd1;
               stall_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, synchronizer and registered outputs; reset aborts any sequence in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         cnt_q         <= 4'd0;
         sync1_q       <= 1'b0;
         sync2_q       <= 1'b0;
         sync3_q       <= 1'b0;
         int_pending_q <= 1'b0;
         cause_q       <= 5'd0;
         exc_pc_q      <= 32'd0;
         exception_q   <= 1'b0;
         eret_q        <= 1'b0;
         redirect_q    <= 1'b0;
         stall_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         sync1_q       <= sync1_d;
         sync2_q       <= sync2_d;
         sync3_q       <= sync3_d;
         int_pending_q <= int_pending_d;
         cause_q       <= cause_d;
         exc_pc_q      <= exc_pc_d;
         exception_q   <= exception_d;
         eret_q        <= eret_d;
         redirect_q    <= redirect_d;
         stall_q       <= stall_d;
      end
   end

   assign bus.exception   = exception_q;
   assign bus.eret        = eret_q;
   assign bus.cause       = cause_q;
   assign bus.exc_pc      = exc_pc_q;
   assign bus.pc_redirect = redirect_q;
   assign bus.pipe_stall  = stall_q | accept;
   assign bus.int_pending = int_pending_q;

endmodule

// File: doc/exc_arbiter.md
EXC_ARBITER -- requirements
Module: exc_arbiter

Interface
REQ-001 Parameter HOLD_CYCLES, default 2, stall cycles after an exception/eret is issued; legal range 0..15.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 syscall_req  in  1  current instruction is SYSCALL.
REQ-005 break_req  in  1  current instruction is BREAK.
REQ-006 teq_req  in  1  current instruction is TEQ with equal operands.
REQ-007 eret_req  in  1  current instruction is ERET.
REQ-008 int_req  in  1  external interrupt, asynchronous to clk, level.
REQ-009 pc_in  in  32  PC of current instruction.
REQ-010 status  in  32  CP0 Status; bit 0 = IE.
REQ-011 exception  out  1  one-cycle pulse to CP0 exception input.
REQ-012 eret  out  1  one-cycle pulse to CP0 eret input.
REQ-013 cause  out  5  exception code to CP0: 0 int, 8 syscall, 9 break, 13 teq.
REQ-014 exc_pc  out  32  PC to CP0 pc input (EPC source).
REQ-015 pc_redirect  out  1  PC mux selects CP0 exc_addr.
REQ-016 pipe_stall  out  1  freeze PC and register-file writes.
REQ-017 int_pending  out  1  latched, not-yet-taken interrupt.

Function
REQ-018 int_req SHALL pass a 2-flop synchronizer; a synchronized rising edge SHALL set int_pending.
REQ-019 int_pending SHALL clear only in the cycle the interrupt is accepted; a new edge arriving in that same cycle SHALL leave it set.
REQ-020 FSM states IDLE, TAKE, HOLD; only IDLE accepts requests.
REQ-021 Acceptance priority in IDLE: syscall > break > teq > eret > interrupt (interrupt only if status[0]=1).
REQ-022 In IDLE, an accepted request SHALL assert pipe_stall combinationally in the same cycle and latch cause and exc_pc=pc_in; next state TAKE.
REQ-023 An accepted eret SHALL latch a separate eret flag; cause and exc_pc are not updated.
REQ-024 In TAKE, exactly one of exception or eret SHALL be 1 for exactly one cycle, with pc_redirect=1 and pipe_stall=1.
REQ-025 From TAKE: if HOLD_CYCLES=0, go to IDLE; otherwise load a 4-bit counter with HOLD_CYCLES-1 and go to HOLD.
REQ-026 In HOLD, pipe_stall=1, pc_redirect=0, exception=eret=0; decrement the counter each cycle; go to IDLE on the cycle the counter is 0.
REQ-027 Requests in TAKE/HOLD SHALL be ignored; only int_pending persists across them.
REQ-028 With status[0]=0, int_pending SHALL stay set and be taken once IE becomes 1 in IDLE.
REQ-029 cause and exc_pc SHALL hold their values between exceptions.
REQ-030 In IDLE with no accepted request, pipe_stall=0, pc_redirect=0, exception=0, eret=0.

Reset
REQ-031 rst_n=0 SHALL immediately force: FSM=IDLE, counter=0, synchronizer=0, int_pending=0, cause=0, exc_pc=0, all 1-bit outputs=0.
REQ-032 Reset asserted during TAKE or HOLD SHALL abort the sequence; no exception/eret pulse after reset release.
REQ-033 The first request SHALL be accepted in the first clk edge after rst_n rises.

Verification
REQ-034 syscall_req=1, pc_in=0x00400020, HOLD_CYCLES=2 -> same cycle pipe_stall=1; next cycle exception=1, cause=8, exc_pc=0x00400020, pc_redirect=1; then 2 HOLD cycles with pipe_stall=1; then IDLE.
REQ-035 syscall_req=1 and teq_req=1 and int_pending=1, status=0x1 -> cause=8 taken; int_pending stays 1; interrupt taken (cause=0) on first IDLE cycle afterwards.
REQ-036 int_req pulse, status=0x0 for 10 cycles, then status=0x1 -> int_pending=1 throughout the 10 cycles, no exception; exception with cause=0 one cycle after IE=1 is accepted.
REQ-037 eret_req=1, pc_in=0x00400100 -> eret=1 for one cycle with pc_redirect=1; exception=0; cause and exc_pc unchanged.
REQ-038 break_req=1, then rst_n=0 during the first HOLD cycle -> all outputs 0 immediately; after release, no pulse occurs and FSM=IDLE.
REQ-039 HOLD_CYCLES=0 with two back-to-back break requests -> exception pulses with cause=9 two cycles apart; the second request is ignored while in TAKE.
